// File: rtl/key_press_classifier_pkg.sv
// Shared state encodings and 50 MHz default timings for the push-button gesture classifier.
package key_press_classifier_pkg;

    typedef enum logic [2:0] {
        KPC_IDLE   = 3'd0,
        KPC_PRESS1 = 3'd1,
        KPC_WAIT2  = 3'd2,
        KPC_PRESS2 = 3'd3,
        KPC_HOLD   = 3'd4
    } kpc_state_e;

    localparam int unsigned KPC_LONG_CYCLES   = 50_000_000;
    localparam int unsigned KPC_DOUBLE_CYCLES = 12_500_000;
    localparam int unsigned KPC_REPEAT_CYCLES = 5_000_000;

    function automatic int unsigned kpc_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_press_classifier_event_timer.sv
// Clearable up-counter that stops at a caller-supplied terminal value and flags when it is there.
module event_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign at_terminal = (cnt_q == terminal);

    // Saturating at the terminal value means the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!at_terminal) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_press_classifier.sv
// Turns a debounced button level into one-cycle short/double/long/repeat gesture pulses.
module key_press_classifier
    import key_press_classifier_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = KPC_LONG_CYCLES,
    parameter int unsigned DOUBLE_CYCLES = KPC_DOUBLE_CYCLES,
    parameter int unsigned REPEAT_CYCLES = KPC_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic       short_press,
    output logic       double_press,
    output logic       long_press,
    output logic       repeat_press,
    output logic [2:0] state
);

    localparam int unsigned MAX_CYCLES = kpc_max3(LONG_CYCLES, DOUBLE_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOUBLE_TERM = CNT_W'(DOUBLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    kpc_state_e       state_q, state_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic [CNT_W-1:0] terminal;
    logic             at_terminal;
    logic             timer_clear;

    always_comb begin
        case (state_q)
            KPC_PRESS1: terminal = LONG_TERM;
            KPC_WAIT2:  terminal = DOUBLE_TERM;
            KPC_HOLD:   terminal = REPEAT_TERM;
            default:    terminal = '0;
        endcase
    end

    // In WAIT2 the terminal count is checked first so a press on that exact edge yields short_press.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            KPC_IDLE: begin
                if (in) state_d = KPC_PRESS1;
            end
            KPC_PRESS1: begin
                if (!in) begin
                    state_d = KPC_WAIT2;
                end else if (at_terminal) begin
                    long_d  = 1'b1;
                    state_d = KPC_HOLD;
                end
            end
            KPC_WAIT2: begin
                if (at_terminal) begin
                    short_d = 1'b1;
                    state_d = KPC_IDLE;
                end else if (in) begin
                    double_d = 1'b1;
                    state_d  = KPC_PRESS2;
                end
            end
            KPC_PRESS2: begin
                if (!in) state_d = KPC_IDLE;
            end
            KPC_HOLD: begin
                if (!in) begin
                    state_d = KPC_IDLE;
                end else if (at_terminal) begin
                    repeat_d = 1'b1;
                end
            end
            default: state_d = KPC_IDLE;
        endcase
    end

    assign timer_clear = (state_d != state_q) || repeat_d;

    event_timer #(.WIDTH(CNT_W)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (timer_clear),
        .terminal    (terminal),
        .at_terminal (at_terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= KPC_IDLE;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign state        = state_q;
    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign repeat_press = repeat_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Scoreboard bench: stimulus queues expected gesture events, a negedge monitor matches DUT pulses against them.
module tb_key_press_classifier;

    localparam int L = 8;
    localparam int D = 4;
    localparam int R = 3;

    localparam logic [3:0] EV_SHORT  = 4'b0001;
    localparam logic [3:0] EV_DOUBLE = 4'b0010;
    localparam logic [3:0] EV_LONG   = 4'b0100;
    localparam logic [3:0] EV_REPEAT = 4'b1000;

    typedef struct {
        logic [3:0] kind;
        int         edge_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in;
    logic       short_press;
    logic       double_press;
    logic       long_press;
    logic       repeat_press;
    logic [2:0] state;

    exp_t exp_q[$];
    int   cyc          = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    key_press_classifier #(
        .LONG_CYCLES   (L),
        .DOUBLE_CYCLES (D),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in           (in),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .repeat_press (repeat_press),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        in = level;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input logic [3:0] kind, input int edge_n);
        exp_t e;
        e.kind   = kind;
        e.edge_n = edge_n;
        exp_q.push_back(e);
    endtask

    // The monitor only reacts when some pulse is high; every such cycle must match the next queued event.
    always @(negedge clk) begin
        logic [3:0] seen;
        exp_t       e;
        seen = {repeat_press, long_press, double_press, short_press};
        if (rst_n === 1'b1 && seen !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_pulse: got pulses %b, expected none (cycle %0d)", seen, cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", 32'(seen), 32'(e.kind));
                checkOutput("event_cycle", cyc, e.edge_n);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        in    = 1'b0;
        #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_pulses", {repeat_press, long_press, double_press, short_press}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 20);
        checkOutput("idle_state", state, 0);

        // Short press: 3 pressed edges, release at c+4, short_press after edge c+8.
        c = cyc;
        expectEvent(EV_SHORT, c + 8);
        applyStimulus(1'b1, 3);
        checkOutput("press1_state", state, 1);
        applyStimulus(1'b0, 12);
        checkOutput("short_done_state", state, 0);

        // Double press: second rising sample at edge c+5.
        c = cyc;
        expectEvent(EV_DOUBLE, c + 5);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        checkOutput("wait2_state", state, 2);
        applyStimulus(1'b1, 5);
        checkOutput("press2_state", state, 3);
        applyStimulus(1'b0, 10);
        checkOutput("double_done_state", state, 0);

        // Long with repeat: t0 = c+1, long at t0+8, repeats at t0+11, t0+14, t0+17.
        c = cyc;
        expectEvent(EV_LONG, c + 9);
        expectEvent(EV_REPEAT, c + 12);
        expectEvent(EV_REPEAT, c + 15);
        expectEvent(EV_REPEAT, c + 18);
        applyStimulus(1'b1, 18);
        checkOutput("hold_state", state, 4);
        applyStimulus(1'b0, 10);
        checkOutput("hold_release_state", state, 0);

        // Press sampled at t1+4 loses to short_press, then becomes a new first press.
        c = cyc;
        expectEvent(EV_SHORT, c + 6);
        expectEvent(EV_SHORT, c + 12);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 1);
        checkOutput("boundary_idle_state", state, 0);
        applyStimulus(1'b1, 1);
        checkOutput("boundary_press1_state", state, 1);
        applyStimulus(1'b0, 10);
        checkOutput("boundary_done_state", state, 0);

        // Released on edge t0+8: no long_press, ordinary short_press instead.
        c = cyc;
        expectEvent(EV_SHORT, c + 13);
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 10);
        checkOutput("almost_long_state", state, 0);

        // Held through edge t0+8: long_press, release from HOLD is silent.
        c = cyc;
        expectEvent(EV_LONG, c + 9);
        applyStimulus(1'b1, 9);
        checkOutput("just_long_state", state, 4);
        applyStimulus(1'b0, 10);
        checkOutput("just_long_done_state", state, 0);

        // Reset in WAIT2 abandons the gesture.
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 1);
        checkOutput("pre_reset_wait2_state", state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_state", state, 0);
        checkOutput("async_reset_pulses", {repeat_press, long_press, double_press, short_press}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 12);
        checkOutput("post_reset_state", state, 0);

        checkOutput("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
